dbgnoc_out_arbiter: RTL
=======================

// Module: dbgnoc_out_arbiter
// PURPOSE
//  Shares one debug-NoC output link between NUM_PORTS packet sources, e.g. several NA output engines.
//  Performs round-robin arbitration per packet and locks the grant until the packet's LAST/SINGLE flit.
//  Sits between the per-source packet buffers and the router injection port.
//  Flit type encoding (top 2 bits of the type field):
//   01 = HEADER, 00 = PAYLOAD, 10 = LAST, 11 = SINGLE.
// PARAMETERS
//  NOC_DATA_WIDTH  32  flit payload width
//  NOC_TYPE_WIDTH  2   flit type width; type is flit[NOC_DATA_WIDTH+1:NOC_DATA_WIDTH], upper bits are passed through
//  NUM_PORTS       4   number of requesters, 2..16
//  (local) NOC_FLIT_WIDTH = NOC_DATA_WIDTH+NOC_TYPE_WIDTH; PTR_W = clog2(NUM_PORTS)
// PORTS
//  clk        in   1                       clock
//  rst        in   1                       synchronous reset, active-low (0 = reset)
//  in_flit    in   NUM_PORTS*FLIT_W        port i occupies [i*FLIT_W +: FLIT_W]
//  in_valid   in   NUM_PORTS               per-port flit valid
//  in_ready   out  NUM_PORTS               per-port flit accepted
//  out_flit   out  NOC_FLIT_WIDTH          flit of the granted port
//  out_valid  out  1                       output flit valid
//  out_ready  in   1                       downstream ready
//  grant      out  NUM_PORTS               one-hot owner of the link; 0 when idle
//  busy       out  1                       high while a packet is in progress (state XFER)
//  proto_err  out  1                       1-cycle pulse, see BEHAVIOUR
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, grant=0, rr_ptr=0, proto_err=0.
//   All outputs are 0 during and after reset until the next arbitration.
//  Reset mid-packet abandons the packet; the downstream sees a truncated packet. This is accepted.
//  Handshake: a flit transfers when valid&&ready at posedge. valid must not depend on ready.
//  State IDLE:
//   - in_ready=0, out_valid=0, out_flit=don't care.
//   - Eligible port: in_valid[i] && type in {HEADER, SINGLE}.
//   - Winner: first eligible port scanning from rr_ptr upward, modulo NUM_PORTS.
//   - If a winner exists: grant<=onehot(winner), rr_ptr<=(winner+1)%NUM_PORTS, state<=XFER.
//   - Arbitration costs exactly 1 bubble cycle per packet.
//   - A valid port showing PAYLOAD or LAST in IDLE is not eligible and is never accepted.
//     proto_err pulses in every such IDLE cycle in which no winner exists.
//  State XFER (g = granted port):
//   - out_flit=in_flit[g], out_valid=in_valid[g], in_ready[g]=out_ready.
//   - Other in_ready bits are 0. Zero-latency combinational forwarding.
//   - On handshake with type LAST or SINGLE: grant<=0, state<=IDLE. Otherwise stay in XFER.
//   - A granted port that drops valid mid-packet keeps the lock indefinitely; there is no preemption.
//   - A HEADER/SINGLE arriving mid-packet on port g is forwarded unchanged.
//  Simultaneous events:
//   - The last-flit handshake and new requests in the same cycle: the new arbitration happens in the following IDLE cycle.
//   - out_ready toggling while valid is held: the flit is held stable by the source; the arbiter adds no state.
//  Fairness: with all ports continuously requesting single-flit packets, each port is granted once every NUM_PORTS packets.
// CONFIGURATION
//  DBGNOC_ARB_FIXED_PRIO_EN defined:
//   - Fixed priority; the lowest-index eligible port always wins.
//   - rr_ptr is removed (held at 0).
//  DBGNOC_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
//  The packet lock, bubble cycle and proto_err are identical in both builds.
// TESTING
//  T1: SINGLE flit 0x3_DEADBEEF on port 0, out_ready=1
//      -> grant=0001 in cycle 1; out_valid and in_ready[0] in cycle 1; IDLE in cycle 2.
//  T2: HEADER on ports 0 and 2 in the same cycle, 3-flit packets each
//      -> port 0's packet is output fully (01,00,10), then port 2's. No interleaving; rr_ptr=3 afterwards.
//  T3: all 4 ports repeat SINGLE for 40 packets -> grant sequence 0,1,2,3,0,... and exactly 10 packets per port.
//  T4: out_ready=0 for 5 cycles mid-packet on port 1 -> out_flit stable, in_ready[1]=0, grant unchanged, no flit lost.
//  T5: port 3 presents LAST in IDLE with no other requests
//      -> in_ready=0, proto_err=1 each cycle; a HEADER on port 3 is then accepted normally.
//  T6: rst=0 asserted mid-packet -> next cycle grant=0, busy=0, out_valid=0; rebuilt with _FIXED_PRIO_EN, T3 -> port 0 always wins.

Source files
------------

// File: rtl/dbgnoc_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dbgnoc_out_arbiter
// Desc     : Shares one debug-NoC output link between NUM_PORTS flit sources.
//            One arbitration bubble per packet. The grant is held until the
//            LAST/SINGLE flit of the packet has been handed downstream.
// Config   : DBGNOC_ARB_FIXED_PRIO_EN defined   -> fixed priority, where the
//                                                 lowest-index port wins and
//                                                 the rotation pointer stays 0.
//            DBGNOC_ARB_FIXED_PRIO_EN undefined -> round-robin (default).
// Revision : 1.0 - initial release
// ============================================================================
module dbgnoc_out_arbiter #(
    parameter int NOC_DATA_WIDTH = 32,
    parameter int NOC_TYPE_WIDTH = 2,
    parameter int NUM_PORTS      = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [NUM_PORTS*(NOC_DATA_WIDTH+NOC_TYPE_WIDTH)-1:0] in_flit,
    input  logic [NUM_PORTS-1:0]                                 in_valid,
    output logic [NUM_PORTS-1:0]                                 in_ready,
    output logic [NOC_DATA_WIDTH+NOC_TYPE_WIDTH-1:0]             out_flit,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [NUM_PORTS-1:0]                                 grant,
    output logic                                                 busy,
    output logic                                                 proto_err
);

    localparam int NOC_FLIT_WIDTH = NOC_DATA_WIDTH + NOC_TYPE_WIDTH;
    localparam int PTR_W          = $clog2(NUM_PORTS);
    // Type bit TYPE_LO is set for HEADER/SINGLE (packet start),
    // type bit TYPE_HI is set for LAST/SINGLE (packet end).
    localparam int TYPE_LO        = NOC_DATA_WIDTH;
    localparam int TYPE_HI        = NOC_DATA_WIDTH + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t                      r_state;
    logic [NUM_PORTS-1:0]        r_grant;
    logic [PTR_W-1:0]            r_rr_ptr;
    logic                        r_proto_err;

    logic [NUM_PORTS-1:0]        w_elig;
    logic [NUM_PORTS-1:0]        w_bad;
    logic                        w_found;
    logic [PTR_W-1:0]            w_win_idx;
    logic [PTR_W:0]              w_cand;
    logic [NUM_PORTS-1:0]        w_win_onehot;
    logic [NOC_FLIT_WIDTH-1:0]   w_out_flit;
    logic                        w_out_valid;
    logic                        w_hs;

    // Per-port classification: a packet may only start with HEADER or SINGLE.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign w_elig[gi] = in_valid[gi] &  in_flit[gi*NOC_FLIT_WIDTH + TYPE_LO];
            assign w_bad[gi]  = in_valid[gi] & ~in_flit[gi*NOC_FLIT_WIDTH + TYPE_LO];
        end
    endgenerate

    // Winner search: first eligible port scanning upward from the pointer, wrapping.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_cand >= (PTR_W+1)'(NUM_PORTS)) begin
                w_cand = w_cand - (PTR_W+1)'(NUM_PORTS);
            end
            if (!w_found && w_elig[w_cand[PTR_W-1:0]]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand[PTR_W-1:0];
            end
        end
    end

    assign w_win_onehot = NUM_PORTS'(1) << w_win_idx;

`ifndef DBGNOC_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0] w_next_ptr;
    assign w_next_ptr = (w_win_idx == PTR_W'(NUM_PORTS-1)) ? '0 : w_win_idx + 1'b1;
`endif

    // Output mux: the one-hot grant selects the forwarded flit; all-zero when idle.
    always_comb begin
        w_out_flit = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_grant[i]) begin
                w_out_flit = w_out_flit | in_flit[i*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH];
            end
        end
    end

    assign w_out_valid = |(r_grant & in_valid);
    assign w_hs        = w_out_valid & out_ready;

    // Arbitration FSM: pick a winner in IDLE, hold the lock until the packet ends.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant  <= w_win_onehot;
`ifndef DBGNOC_ARB_FIXED_PRIO_EN
                        r_rr_ptr <= w_next_ptr;
`endif
                        r_state  <= ST_XFER;
                    end else if (|w_bad) begin
                        r_proto_err <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (w_hs && w_out_flit[TYPE_HI]) begin
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_flit  = w_out_flit;
    assign out_valid = w_out_valid;
    assign in_ready  = r_grant & {NUM_PORTS{out_ready}};
    assign grant     = r_grant;
    assign busy      = (r_state == ST_XFER);
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire
